// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, ready/valid imem requests, in-order prefetch queue, IF/ID register.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_bubbles counter ports.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        Reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST = DEPTH - 1;
    localparam logic [PW-1:0] LAST_PTR = LAST[PW-1:0];
    localparam logic [CW:0]   DEPTH_C  = DEPTH[CW:0];

    logic [63:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [63:0]   tag_mem [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [63:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] q_head;
    logic [PW-1:0] q_tail;
    logic [CW:0]   occupancy;
    logic          accept;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Credit rule: in-flight requests plus buffered words never exceed the queue depth.
    assign occupancy = {1'b0, inflight} + {1'b0, count};
    assign imem_req  = !Reset && !redirect && (occupancy < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign push      = imem_rvalid && !redirect && (drop == '0);
    assign pop       = !redirect && !stall && (count != '0);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            q_head   <= '0;
            q_tail   <= '0;
            id_valid <= 1'b0;
            id_instr <= 32'h0;
            id_pc    <= 64'h0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 64'd4;
                tag_wr   <= next_ptr(tag_wr);
            end
            // Tags pop on every response, dropped or not, so they stay aligned with inflight.
            if (imem_rvalid)
                tag_rd <= next_ptr(tag_rd);
            inflight <= inflight + CW'(accept) - CW'(imem_rvalid);
            if (redirect) begin
                fetch_pc <= {redirect_pc[63:2], 2'b00};
                drop     <= inflight - CW'(imem_rvalid);
                count    <= '0;
                q_head   <= '0;
                q_tail   <= '0;
                id_valid <= 1'b0;
            end else begin
                if (imem_rvalid && (drop != '0))
                    drop <= drop - CW'(1);
                if (push)
                    q_tail <= next_ptr(q_tail);
                if (pop)
                    q_head <= next_ptr(q_head);
                count <= count + CW'(push) - CW'(pop);
                if (pop) begin
                    id_valid <= 1'b1;
                    id_instr <= q_instr[q_head];
                    id_pc    <= q_pc[q_head];
                end else if (!stall) begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            q_pc[q_tail]    <= tag_mem[tag_rd];
            q_instr[q_tail] <= imem_rdata;
        end
    end

    response_needs_request: assert property (
        @(posedge clk) disable iff (Reset) imem_rvalid |-> (inflight != '0));

`ifdef FETCH_PERF_EN
    logic bubble;
    assign bubble = !redirect && !stall && (count == '0);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            perf_fetched <= 32'h0;
            perf_bubbles <= 32'h0;
        end else begin
            if (pop && (perf_fetched != 32'hFFFF_FFFF))
                perf_fetched <= perf_fetched + 32'd1;
            if (bubble && (perf_bubbles != 32'hFFFF_FFFF))
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`else
    // Core-only build: no performance counters exist.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with an in-order, variable-latency memory model.
module tb_fetch_stage;
    logic        clk;
    logic        Reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int checks;
    int errors;

    fetch_stage #(.RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk(clk), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B020020;
        if (a == 64'h4) return 32'hCB030041;
        return a[31:0] ^ a[63:32] ^ 32'h5A00_0000;
    endfunction

    // Memory model: lat_mode 0 = 1 cycle, 1 = cycling 1/3/2, 2 = 4 cycles.
    // ready_mode 0 = always ready, 1 = toggling, 2 = never ready.
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    int          cycle;
    int          last_due;
    int          lat_idx;
    int          lat_mode;
    int          ready_mode;

    always @(posedge clk) begin : mem_accept
        int lat;
        int due;
        cycle = cycle + 1;
        if (Reset) begin
            pend_addr.delete();
            pend_due.delete();
            last_due = 0;
            lat_idx  = 0;
        end else if (imem_req && imem_ready) begin
            case (lat_mode)
                1: begin
                    case (lat_idx % 3)
                        0: lat = 1;
                        1: lat = 3;
                        default: lat = 2;
                    endcase
                    lat_idx = lat_idx + 1;
                end
                2: lat = 4;
                default: lat = 1;
            endcase
            due = cycle + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(due);
        end
    end

    always @(negedge clk) begin
        case (ready_mode)
            1: imem_ready = ~imem_ready;
            2: imem_ready = 1'b0;
            default: imem_ready = 1'b1;
        endcase
        if (!Reset && (pend_due.size() > 0) && (pend_due[0] <= cycle + 1)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Occupancy invariant: in-flight requests plus queued words never exceed DEPTH.
    always @(negedge clk) begin
        if (!Reset) begin
            checks++;
            assert (int'(dut.inflight) + int'(dut.count) <= 2) else begin
                errors++;
                $display("[TB] FAIL occupancy: inflight+count=%0d, required <= 2",
                         int'(dut.inflight) + int'(dut.count));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input int lmode, input int rmode);
        stall    = 1'b1;
        redirect = 1'b0;
        repeat (12) tick();
        Reset      = 1'b1;
        lat_mode   = lmode;
        ready_mode = rmode;
        stall      = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b, expected 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", id_valid); end
        checks++; if (id_pc !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h, expected 0", id_pc); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h, expected 0", id_instr); end
        Reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b, expected 1", imem_req); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL first_addr: got %h, expected 0", imem_addr); end
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_cycle1: got %b, expected 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_cycle2: got %b, expected 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instr !== 32'h8B020020) begin
            errors++; $display("[TB] FAIL first_instr: got v=%b pc=%h i=%h, expected v=1 pc=0 i=8b020020", id_valid, id_pc, id_instr); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'h4 || id_instr !== 32'hCB030041) begin
            errors++; $display("[TB] FAIL second_instr: got v=%b pc=%h i=%h, expected v=1 pc=4 i=cb030041", id_valid, id_pc, id_instr); end
        tick();
        checks++; if (id_valid !== 1'b0 || id_pc !== 64'h4 || id_instr !== 32'hCB030041) begin
            errors++; $display("[TB] FAIL bubble_hold: got v=%b pc=%h i=%h, expected v=0 pc=4 i=cb030041", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_stall();
        int n;
        n = 0;
        while (!id_valid && n < 10) begin tick(); n++; end
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8) begin
            errors++; $display("[TB] FAIL pre_stall: got v=%b pc=%h, expected v=1 pc=8", id_valid, id_pc); end
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8 || id_instr !== mem_word(64'h8)) begin
                errors++; $display("[TB] FAIL stall_hold%0d: got v=%b pc=%h i=%h, expected v=1 pc=8 i=%h",
                                   c, id_valid, id_pc, id_instr, mem_word(64'h8)); end
        end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_credit: got req=%b, expected 0", imem_req); end
        stall = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'hC) begin
            errors++; $display("[TB] FAIL resume_12: got v=%b pc=%h, expected v=1 pc=c", id_valid, id_pc); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'h10) begin
            errors++; $display("[TB] FAIL resume_16: got v=%b pc=%h, expected v=1 pc=10", id_valid, id_pc); end
    endtask

    task automatic test_variable_latency();
        int n;
        restart(1, 1);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!id_valid && n < 20) begin tick(); n++; end
            checks++; if (id_valid !== 1'b1 || id_pc !== 64'(4 * k) || id_instr !== mem_word(64'(4 * k))) begin
                errors++; $display("[TB] FAIL varlat_%0d: got v=%b pc=%h i=%h, expected v=1 pc=%h i=%h",
                                   k, id_valid, id_pc, id_instr, 64'(4 * k), mem_word(64'(4 * k))); end
            tick();
        end
    endtask

    task automatic test_redirect();
        int n;
        restart(2, 0);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h1003;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redirect_req: got %b, expected 0", imem_req); end
        tick();
        redirect = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redirect_valid: got %b, expected 0", id_valid); end
        checks++; if (imem_addr !== 64'h1000) begin errors++; $display("[TB] FAIL redirect_addr: got %h, expected 1000", imem_addr); end
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!id_valid && n < 30) begin tick(); n++; end
            checks++; if (id_valid !== 1'b1 || id_pc !== 64'h1000 + 64'(4 * k) || id_instr !== mem_word(64'h1000 + 64'(4 * k))) begin
                errors++; $display("[TB] FAIL redirect_seq%0d: got v=%b pc=%h i=%h, expected v=1 pc=%h",
                                   k, id_valid, id_pc, id_instr, 64'h1000 + 64'(4 * k)); end
            tick();
        end
    endtask

    task automatic test_pc_wrap();
        int n;
        logic [63:0] exp_pc;
        lat_mode    = 0;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        exp_pc   = 64'hFFFF_FFFF_FFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!id_valid && n < 30) begin tick(); n++; end
            checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== mem_word(exp_pc)) begin
                errors++; $display("[TB] FAIL wrap_seq%0d: got v=%b pc=%h i=%h, expected v=1 pc=%h i=%h",
                                   k, id_valid, id_pc, id_instr, exp_pc, mem_word(exp_pc)); end
            exp_pc = exp_pc + 64'd4;
            tick();
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        restart(0, 2);
        repeat (10) tick();
        checks++; if (perf_bubbles !== 32'd10 || perf_fetched !== 32'd0) begin
            errors++; $display("[TB] FAIL perf_bubbles: got b=%0d f=%0d, expected b=10 f=0", perf_bubbles, perf_fetched); end
        for (int r = 1; r <= 2; r++) begin
            stall      = 1'b1;
            ready_mode = 0;
            repeat (5) tick();
            stall = 1'b0;
            tick();
            tick();
            stall = 1'b1;
            checks++; if (perf_fetched !== 32'(2 * r) || perf_bubbles !== 32'd10) begin
                errors++; $display("[TB] FAIL perf_round%0d: got f=%0d b=%0d, expected f=%0d b=10",
                                   r, perf_fetched, perf_bubbles, 2 * r); end
        end
        stall = 1'b0;
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        cycle       = 0;
        last_due    = 0;
        lat_idx     = 0;
        lat_mode    = 0;
        ready_mode  = 0;
        Reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        test_reset();
        test_stall();
        test_variable_latency();
        test_redirect();
        test_pc_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
